// File: rtl/dec_alu_pipe_pkg.sv
// Shared definitions for the decode-to-ALU pipeline stage.
// Holds the default field widths (matching the DataSize / RegAddrSize /
// ALUControlBus definitions), the fixed low-order payload offsets, a helper
// that returns the packed payload width, and the occupancy state encoding.
package dec_alu_pipe_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_ALU_OP_W   = 4;

  // Payload layout, LSB first: dc_re, reg_we, wb_addr, op, imm, data2, data1.
  localparam int unsigned OFF_DC_RE   = 0;
  localparam int unsigned OFF_REG_WE  = 1;
  localparam int unsigned OFF_WB_ADDR = 2;

  // Total packed payload width for a given set of field widths.
  function automatic int unsigned payload_w(input int unsigned data_w,
                                            input int unsigned reg_addr_w,
                                            input int unsigned alu_op_w);
    return 3 * data_w + alu_op_w + reg_addr_w + 2;
  endfunction

  // Bit 0 = main entry valid, bit 1 = skid entry valid; both bits are
  // used directly as the registered valid flags.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } occ_e;

endpackage

// File: rtl/dec_alu_pipe_skid.sv
// pipe_skid_buf: generic width-P valid/ready pipeline register with an
// optional second (skid) entry, synchronous reset and flush.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every held entry and the one offered this cycle
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
// CLR_MASK selects payload bits forced to 0 in the main register whenever
// it goes empty, so those bits read 0 during bubbles.
module pipe_skid_buf
  import dec_alu_pipe_pkg::*;
#(
  parameter int unsigned  P        = 8,
  parameter bit           SKID     = 1'b1,
  parameter logic [P-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_data
);

  occ_e         state_q;
  occ_e         state_d;
  logic [P-1:0] main_q;
  logic [P-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;
  logic         load_main_in;
  logic         load_main_skid;
  logic         load_skid;
  logic         clr_main;

  assign out_valid = state_q[0];
  assign out_data  = main_q;

  // in_ready: registered skid-empty flag, or pass-through of downstream ready.
  // Held low while in reset so nothing is accepted during rst.
  generate
    if (SKID) begin : g_reg_ready
      assign in_ready = ~state_q[1] & ~rst;
    end else begin : g_comb_ready
      assign in_ready = (~state_q[0] | out_ready) & ~rst;
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush empties the stage regardless of handshakes.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_ready) begin
            state_d = ST_TWO;
          end else if (!in_fire && out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO:   if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Datapath control decoded from state and handshakes.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main       = 1'b0;
    if (flush) begin
      clr_main = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: load_main_in = in_fire;
        ST_ONE: begin
          if (in_fire && out_ready) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
          end else if (out_fire) begin
            clr_main = 1'b1;
          end
        end
        ST_TWO:   load_main_skid = out_fire;
        default:  clr_main = 1'b1;
      endcase
    end
  end

  // Payload registers; the clear mask keeps bubble-sensitive bits at 0
  // whenever the main entry is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end else if (clr_main) begin
        main_q <= main_q & ~CLR_MASK;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/dec_alu_pipe.sv
// dec_alu_pipe: valid/ready pipeline register between decode and the ALU.
// Packs the decoded fields into one payload, holds it in pipe_skid_buf and
// unpacks the registered copy toward the ALU / ALU_MEM stage.
// Ports:
//   clk, rst, flush                 clock, sync active-high reset, squash
//   in_valid/in_ready               upstream handshake
//   in_data1, in_data2, in_imm      operands and immediate
//   in_op, in_wb_addr               ALU operation, destination register
//   in_reg_we, in_dc_re             register write / data-cache read enables
//   out_valid/out_ready             downstream handshake
//   out_*                           registered copies of the in_* fields
module dec_alu_pipe
  import dec_alu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned ALU_OP_W   = DEF_ALU_OP_W,
  parameter bit          SKID       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data1,
  input  logic [DATA_W-1:0]     in_data2,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [ALU_OP_W-1:0]   in_op,
  input  logic [REG_ADDR_W-1:0] in_wb_addr,
  input  logic                  in_reg_we,
  input  logic                  in_dc_re,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data1,
  output logic [DATA_W-1:0]     out_data2,
  output logic [DATA_W-1:0]     out_imm,
  output logic [ALU_OP_W-1:0]   out_op,
  output logic [REG_ADDR_W-1:0] out_wb_addr,
  output logic                  out_reg_we,
  output logic                  out_dc_re
);

  localparam int unsigned P         = payload_w(DATA_W, REG_ADDR_W, ALU_OP_W);
  localparam int unsigned OFF_OP    = OFF_WB_ADDR + REG_ADDR_W;
  localparam int unsigned OFF_IMM   = OFF_OP + ALU_OP_W;
  localparam int unsigned OFF_DATA2 = OFF_IMM + DATA_W;
  localparam int unsigned OFF_DATA1 = OFF_DATA2 + DATA_W;

  // Side-effecting enables must never be seen asserted during a bubble.
  localparam logic [P-1:0] BUBBLE_CLR = (P'(1) << OFF_REG_WE) | (P'(1) << OFF_DC_RE);

  logic [P-1:0] pl_in;
  logic [P-1:0] pl_out;

  assign pl_in = {in_data1, in_data2, in_imm, in_op, in_wb_addr, in_reg_we, in_dc_re};

  pipe_skid_buf #(
    .P        (P),
    .SKID     (SKID),
    .CLR_MASK (BUBBLE_CLR)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out)
  );

  assign out_data1   = pl_out[OFF_DATA1 +: DATA_W];
  assign out_data2   = pl_out[OFF_DATA2 +: DATA_W];
  assign out_imm     = pl_out[OFF_IMM +: DATA_W];
  assign out_op      = pl_out[OFF_OP +: ALU_OP_W];
  assign out_wb_addr = pl_out[OFF_WB_ADDR +: REG_ADDR_W];
  assign out_reg_we  = pl_out[OFF_REG_WE];
  assign out_dc_re   = pl_out[OFF_DC_RE];

endmodule

// File: tb/tb_dec_alu_pipe.sv
// Directed, table-driven bench for dec_alu_pipe: one SKID=1 instance driven
// from a per-cycle vector table, one SKID=0 instance checked against a
// small occupancy model under toggling backpressure.
module tb_dec_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid, in_valid0;
  logic        out_ready, out_ready0;
  logic [31:0] in_data1, in_data2, in_imm;
  logic [3:0]  in_op;
  logic [4:0]  in_wb_addr;
  logic        in_reg_we, in_dc_re;

  logic        ir, ov, owe, ore;
  logic [31:0] od1, od2, oimm;
  logic [3:0]  oop;
  logic [4:0]  owb;

  logic        ir0, ov0, owe0, ore0;
  logic [31:0] od1_0, od2_0, oimm_0;
  logic [3:0]  oop_0;
  logic [4:0]  owb_0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_alu_pipe #(.SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir),
    .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm),
    .in_op(in_op), .in_wb_addr(in_wb_addr), .in_reg_we(in_reg_we), .in_dc_re(in_dc_re),
    .out_valid(ov), .out_ready(out_ready),
    .out_data1(od1), .out_data2(od2), .out_imm(oimm), .out_op(oop),
    .out_wb_addr(owb), .out_reg_we(owe), .out_dc_re(ore)
  );

  dec_alu_pipe #(.SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid0), .in_ready(ir0),
    .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm),
    .in_op(in_op), .in_wb_addr(in_wb_addr), .in_reg_we(in_reg_we), .in_dc_re(in_dc_re),
    .out_valid(ov0), .out_ready(out_ready0),
    .out_data1(od1_0), .out_data2(od2_0), .out_imm(oimm_0), .out_op(oop_0),
    .out_wb_addr(owb_0), .out_reg_we(owe0), .out_dc_re(ore0)
  );

  typedef struct {
    logic        iv, ord, fl;
    logic [31:0] d1;
    logic [3:0]  op;
    logic        we, re;
    logic        e_ov, e_ir;
    logic [31:0] e_d1;
    logic [3:0]  e_op;
    logic        e_we, e_re;
  } vec_t;

  vec_t tbl[$];

  // Secondary fields are derived from data1 so one number identifies an entry.
  function automatic logic [31:0] f_d2(input logic [31:0] d1);
    return d1 ^ 32'hFFFF_0000;
  endfunction
  function automatic logic [31:0] f_imm(input logic [31:0] d1);
    return d1 + 32'd100;
  endfunction
  function automatic logic [4:0] f_wb(input logic [31:0] d1);
    return d1[4:0];
  endfunction

  function automatic vec_t mk(input logic iv, input logic ord, input logic fl,
                              input logic [31:0] d1, input logic [3:0] op,
                              input logic we, input logic re,
                              input logic e_ov, input logic e_ir,
                              input logic [31:0] e_d1, input logic [3:0] e_op,
                              input logic e_we, input logic e_re);
    vec_t v;
    v.iv = iv; v.ord = ord; v.fl = fl; v.d1 = d1; v.op = op; v.we = we; v.re = re;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_d1 = e_d1; v.e_op = e_op; v.e_we = e_we; v.e_re = e_re;
    return v;
  endfunction

  task automatic set_entry(input logic [31:0] d1, input logic [3:0] op,
                           input logic we, input logic re);
    in_data1   = d1;
    in_data2   = f_d2(d1);
    in_imm     = f_imm(d1);
    in_op      = op;
    in_wb_addr = f_wb(d1);
    in_reg_we  = we;
    in_dc_re   = re;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic        m_ov;
  logic [31:0] m_d;
  logic [31:0] n_in, n_out;
  logic        s_ord, s_eir;

  initial begin
    // Reset held 3 cycles with a valid entry offered.
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_valid0 = 1'b1;
    out_ready = 1'b0; out_ready0 = 1'b0;
    set_entry(32'h1234_5678, 4'h9, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst%0d out_valid", c), 32'(ov), 32'd0);
      chk($sformatf("rst%0d in_ready", c), 32'(ir), 32'd0);
      chk($sformatf("rst%0d in_ready skid0", c), 32'(ir0), 32'd0);
      chk($sformatf("rst%0d data1", c), od1, 32'd0);
      chk($sformatf("rst%0d data2", c), od2, 32'd0);
      chk($sformatf("rst%0d imm", c), oimm, 32'd0);
      chk($sformatf("rst%0d op/wb", c), {23'd0, oop, owb}, 32'd0);
      chk($sformatf("rst%0d we/re", c), {30'd0, owe, ore}, 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
    out_ready = 1'b1; out_ready0 = 1'b1;
    @(posedge clk); #1;
    chk("post-rst in_ready", 32'(ir), 32'd1);
    chk("post-rst in_ready skid0", 32'(ir0), 32'd1);
    chk("post-rst out_valid", 32'(ov), 32'd0);

    // Streaming: 8 back-to-back entries, out_ready high.
    for (int k = 1; k <= 8; k++) begin
      tbl.push_back(mk(1, 1, 0, 32'(k), 4'(k), 1, 1'(k % 2),
                       1, 1, 32'(k), 4'(k), 1, 1'(k % 2)));
    end
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0));
    // Bubble after a reg_we/dc_re entry is consumed.
    tbl.push_back(mk(1, 1, 0, 32'h55, 4'h5, 1, 1,   1, 1, 32'h55, 4'h5, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    // Backpressure: A presented, B into skid, C stalled, then drain A,B,C.
    tbl.push_back(mk(1, 0, 0, 32'hA0, 4'hA, 1, 0,   1, 1, 32'hA0, 4'hA, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'hB0, 4'hB, 0, 1,   1, 0, 32'hA0, 4'hA, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'hC0, 4'hC, 1, 1,   1, 0, 32'hA0, 4'hA, 1, 0));
    tbl.push_back(mk(1, 1, 0, 32'hC0, 4'hC, 1, 1,   1, 1, 32'hB0, 4'hB, 0, 1));
    tbl.push_back(mk(1, 1, 0, 32'hC0, 4'hC, 1, 1,   1, 1, 32'hC0, 4'hC, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    // Flush while TWO is full with D offered; D must never appear.
    tbl.push_back(mk(1, 0, 0, 32'hE0, 4'hE, 1, 1,   1, 1, 32'hE0, 4'hE, 1, 1));
    tbl.push_back(mk(1, 0, 0, 32'hF0, 4'hF, 1, 1,   1, 0, 32'hE0, 4'hE, 1, 1));
    tbl.push_back(mk(1, 0, 1, 32'hD0, 4'hD, 1, 1,   0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    // Flush together with out_fire, then the stage works normally again.
    tbl.push_back(mk(1, 1, 0, 32'h61, 4'h6, 1, 1,   1, 1, 32'h61, 4'h6, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h72, 4'h7, 0, 1,   1, 1, 32'h72, 4'h7, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,           0, 1, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].iv; out_ready = tbl[i].ord; flush = tbl[i].fl;
      set_entry(tbl[i].d1, tbl[i].op, tbl[i].we, tbl[i].re);
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", i), 32'(ov), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d in_ready", i), 32'(ir), 32'(tbl[i].e_ir));
      chk($sformatf("row%0d reg_we", i), 32'(owe), 32'(tbl[i].e_we));
      chk($sformatf("row%0d dc_re", i), 32'(ore), 32'(tbl[i].e_re));
      if (tbl[i].e_ov) begin
        chk($sformatf("row%0d data1", i), od1, tbl[i].e_d1);
        chk($sformatf("row%0d data2", i), od2, f_d2(tbl[i].e_d1));
        chk($sformatf("row%0d imm", i), oimm, f_imm(tbl[i].e_d1));
        chk($sformatf("row%0d op", i), 32'(oop), 32'(tbl[i].e_op));
        chk($sformatf("row%0d wb_addr", i), 32'(owb), 32'(f_wb(tbl[i].e_d1)));
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

    // SKID=0: continuous in_valid, out_ready toggling 1010...
    m_ov = 1'b0; m_d = '0; n_in = 32'h100; n_out = 32'h100;
    for (int c = 0; c < 12; c++) begin
      s_ord = (c % 2 == 0);
      out_ready0 = s_ord; in_valid0 = 1'b1;
      set_entry(n_in, n_in[3:0], 1'b1, 1'b0);
      #1;
      s_eir = ~m_ov | s_ord;
      chk($sformatf("s0 c%0d in_ready", c), 32'(ir0), 32'(s_eir));
      if (m_ov && s_ord) begin
        chk($sformatf("s0 c%0d delivered", c), od1_0, n_out);
        n_out = n_out + 32'd1;
      end
      if (s_eir) begin
        m_ov = 1'b1; m_d = n_in; n_in = n_in + 32'd1;
      end else if (s_ord) begin
        m_ov = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("s0 c%0d out_valid", c), 32'(ov0), 32'(m_ov));
      if (m_ov) begin
        chk($sformatf("s0 c%0d data1", c), od1_0, m_d);
        chk($sformatf("s0 c%0d op", c), 32'(oop_0), 32'(m_d[3:0]));
      end
    end
    in_valid0 = 1'b0;
    chk("s0 entries accepted", n_in - 32'h100, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
